// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates an instruction-fetch port and a data port onto one
// shared single-port memory with a fixed read latency.
//
// Parameter:
//   MEM_LAT    memory read latency (1..4) from the mem_en cycle to the edge
//              that samples mem_rdata
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch request (held until if_ack) and address
//   if_rdata/if_ack          registered fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata data request (held until d_ack), write enable,
//                            address, write data
//   d_rdata/d_ack            registered read word, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  registered memory drive
//   mem_rdata                memory read data
//   stall_if/stall_mem       pipeline stall requests (combinational)
//   busy                     high while an access is in flight
// Build option:
//   MEM_ARB_RR_EN  defined: round-robin on simultaneous requests
//                  undefined: data request has fixed priority over fetch
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 2
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        if_req,
   input  logic [15:0] if_addr,
   output logic [15:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_ack,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        stall_if,
   output logic        stall_mem,
   output logic        busy
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cnt;
   logic       grant_d;   // 1 = data port owns the in-flight access
   logic       sel_d;     // requester chosen at a grant edge
   logic       any_req;
   logic       done;

   assign any_req = if_req | d_req;
   // Counter reaches zero on this edge: grant edge + MEM_LAT
   assign done    = (state == ACCESS) && (cnt == 3'd1);

`ifdef MEM_ARB_RR_EN
   logic last_d;          // 1 = data port was granted most recently

   always_comb begin
      sel_d = d_req;
      if (if_req && d_req)
         sel_d = ~last_d;
   end

   always_ff @(posedge Clk) begin
      if (Rst)
         last_d <= 1'b0;
      else if (state == IDLE && any_req)
         last_d <= sel_d;
   end
`else
   always_comb begin
      sel_d = d_req;
   end
`endif

   // State register
   always_ff @(posedge Clk) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ACCESS;
         ACCESS:  if (done)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational outputs
   always_comb begin
      busy      = (state == ACCESS);
      stall_if  = if_req & ~if_ack;
      stall_mem = d_req & ~d_ack;
   end

   // Registered datapath: grant latch, latency counter, read capture, acks
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt       <= '0;
         grant_d   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
      end else begin
         mem_en <= 1'b0;
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         if (state == IDLE && any_req) begin
            grant_d <= sel_d;
            cnt     <= 3'(MEM_LAT);
            mem_en  <= 1'b1;
            if (sel_d) begin
               mem_we    <= d_we;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
            end else begin
               mem_we    <= 1'b0;
               mem_addr  <= if_addr;
               mem_wdata <= '0;
            end
         end
         if (state == ACCESS) begin
            cnt <= cnt - 3'd1;
            if (done) begin
               if (grant_d) begin
                  d_ack <= 1'b1;
                  if (!mem_we)
                     d_rdata <= mem_rdata;
               end else begin
                  if_ack   <= 1'b1;
                  if_rdata <= mem_rdata;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- randomized self-checking bench for mem_arbiter.
// A transaction-level reference model tracks the in-flight access by the
// edge number of its grant and predicts every output after each rising edge.
// Builds with or without MEM_ARB_RR_EN; the model follows the same macro.
module tb_mem_arbiter;

   localparam int unsigned MEM_LAT = 2;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        if_req = 1'b0;
   logic [15:0] if_addr = '0;
   logic [15:0] if_rdata;
   logic        if_ack;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [15:0] d_addr = '0;
   logic [15:0] d_wdata = '0;
   logic [15:0] d_rdata;
   logic        d_ack;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata = '0;
   logic        stall_if;
   logic        stall_mem;
   logic        busy;

   mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
      .Clk(Clk), .Rst(Rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
   );

   always #5 Clk = ~Clk;

   int n_chk = 0;
   int n_err = 0;
   int edge_n = 0;

   // Reference model state
   bit          m_active = 1'b0;
   int          m_g = 0;          // edge number of the current grant
   bit          m_who_d = 1'b0;
   bit          m_last_d = 1'b0;
   logic        m_we = 1'b0;
   logic [15:0] m_addr = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] m_if_rdata = '0;
   logic [15:0] m_d_rdata = '0;
   bit          m_if_ack = 1'b0;
   bit          m_d_ack = 1'b0;
   bit          m_mem_en = 1'b0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
      end
   endtask

   // Applies the arbitration rules to the inputs seen at this edge.
   task automatic model_edge();
      bit pick_d;
      m_if_ack = 1'b0;
      m_d_ack  = 1'b0;
      m_mem_en = 1'b0;
      if (Rst) begin
         m_active   = 1'b0;
         m_we       = 1'b0;
         m_addr     = '0;
         m_wdata    = '0;
         m_if_rdata = '0;
         m_d_rdata  = '0;
         m_last_d   = 1'b0;
      end else if (m_active) begin
         if (edge_n == m_g + int'(MEM_LAT)) begin
            m_active = 1'b0;
            if (m_who_d) begin
               m_d_ack = 1'b1;
               if (!m_we) m_d_rdata = mem_rdata;
            end else begin
               m_if_ack   = 1'b1;
               m_if_rdata = mem_rdata;
            end
         end
      end else if (if_req || d_req) begin
`ifdef MEM_ARB_RR_EN
         pick_d = (if_req && d_req) ? !m_last_d : d_req;
`else
         pick_d = d_req;
`endif
         m_last_d = pick_d;
         m_who_d  = pick_d;
         m_we     = pick_d ? d_we : 1'b0;
         m_addr   = pick_d ? d_addr : if_addr;
         m_wdata  = pick_d ? d_wdata : 16'h0000;
         m_g      = edge_n;
         m_active = 1'b1;
         m_mem_en = 1'b1;
      end
   endtask

   task automatic compare_all();
      check("if_ack",    {15'd0, if_ack},    {15'd0, m_if_ack});
      check("d_ack",     {15'd0, d_ack},     {15'd0, m_d_ack});
      check("ack_excl",  {15'd0, if_ack & d_ack}, 16'h0000);
      check("mem_en",    {15'd0, mem_en},    {15'd0, m_mem_en});
      check("mem_we",    {15'd0, mem_we},    {15'd0, m_we});
      check("mem_addr",  mem_addr,           m_addr);
      check("mem_wdata", mem_wdata,          m_wdata);
      check("if_rdata",  if_rdata,           m_if_rdata);
      check("d_rdata",   d_rdata,            m_d_rdata);
      check("busy",      {15'd0, busy},      {15'd0, m_active});
      check("stall_if",  {15'd0, stall_if},  {15'd0, if_req & ~m_if_ack});
      check("stall_mem", {15'd0, stall_mem}, {15'd0, d_req & ~m_d_ack});
   endtask

   task automatic step();
      @(posedge Clk);
      edge_n++;
      model_edge();
      #1;
      compare_all();
   endtask

   // Runs n cycles; each requester drops its request in its ack cycle.
   task automatic run_drop(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if (m_if_ack) if_req = 1'b0;
         if (m_d_ack)  d_req  = 1'b0;
      end
   endtask

   initial begin
      // Reset with random inputs
      Rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
         if_addr = 16'($urandom); d_addr = 16'($urandom);
         d_wdata = 16'($urandom); mem_rdata = 16'($urandom);
         step();
      end
      Rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
      step();

      // Single fetch
      if_req = 1'b1; if_addr = 16'h0010; mem_rdata = 16'hA5A5;
      run_drop(5);

      // Simultaneous write and fetch
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'h1234;
      if_req = 1'b1; if_addr = 16'h0014; mem_rdata = 16'h0F0F;
      run_drop(9);

      // Both held over four accesses
      d_req = 1'b1; d_we = 1'b0; if_req = 1'b1;
      for (int i = 0; i < 12; i++) begin
         mem_rdata = 16'($urandom);
         step();
      end
      if_req = 1'b0; d_req = 1'b0;
      run_drop(4);

      // Reset pulsed mid-access, then a fresh fetch
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040; mem_rdata = 16'h7777;
      run_drop(2);
      Rst = 1'b1; d_req = 1'b0;
      step();
      Rst = 1'b0;
      step();
      if_req = 1'b1; if_addr = 16'h0020; mem_rdata = 16'h5A5A;
      run_drop(5);

      // Address change after grant must not disturb the access
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300; mem_rdata = 16'hC3C3;
      run_drop(1);
      d_addr = 16'h0304;
      run_drop(5);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         step();
         Rst = ($urandom_range(0, 49) == 0);
         if (if_req) begin
            if (m_if_ack && $urandom_range(0, 1) == 0) if_req = 1'b0;
            else if ($urandom_range(0, 7) == 0) if_addr = 16'($urandom);
         end else if ($urandom_range(0, 2) == 0) begin
            if_req = 1'b1; if_addr = 16'($urandom);
         end
         if (d_req) begin
            if (m_d_ack && $urandom_range(0, 1) == 0) d_req = 1'b0;
            else if ($urandom_range(0, 7) == 0) begin
               d_addr = 16'($urandom); d_wdata = 16'($urandom); d_we = 1'($urandom);
            end
         end else if ($urandom_range(0, 2) == 0) begin
            d_req = 1'b1; d_we = 1'($urandom);
            d_addr = 16'($urandom); d_wdata = 16'($urandom);
         end
         mem_rdata = 16'($urandom);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
